exec_sequencer: RTL
===================

Name: exec_sequencer

Overview:
- Central multi-cycle controller for the single-issue core. Sequences each instruction through fetch, execute, optional memory access and commit.
- Produces the single commit strobe that gates the PC, GPR and CSR writes.
- Detects ebreak, bus errors and stalled handshakes, and halts the core with a cause code.
- Maintains the 64-bit cycle and retired-instruction counters.

Parameters:
- WDT_LIMIT, 1024: cycles allowed in FETCH or MEM before a watchdog halt; legal range 2..65535.
- CNT_W, 64: width of the mcycle and minstret counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ifu_valid  in  1  IFU instruction valid for the current pc
- ifu_err  in  1  IFU fetch response not OKAY; qualified by ifu_valid
- idu_ready  out  1  core ready to accept the fetched instruction
- is_mem  in  1  decoded instruction needs the LSU; valid in EXEC
- is_ebreak  in  1  decoded instruction is ebreak; valid in EXEC
- exu_valid  out  1  request to LSU
- lsu_ready  in  1  LSU accepts the request
- lsu_valid  in  1  LSU access complete
- lsu_err  in  1  LSU bus response not OKAY; qualified by lsu_valid
- commit  out  1  one-cycle strobe enabling PC, GPR and CSR writes
- halt  out  1  core halted; sticky until rst
- halt_code  out  2  0 none, 1 ebreak, 2 bus error, 3 watchdog
- mcycle  out  CNT_W  cycle counter
- minstret  out  CNT_W  retired-instruction counter
- state_dbg  out  3  current state encoding

Behaviour:
- States and encodings: IDLE=0, FETCH=1, EXEC=2, MEM=3, COMMIT=4, HALT=5. All registered; all outputs are Moore-decoded from the state.
- Reset (rst high at a clock edge), including mid-operation:
  - state goes to IDLE.
  - mcycle, minstret, halt_code, watchdog counter, mem_q and ebreak_q clear to 0.
  - commit, exu_valid, idu_ready and halt read 0.
- IDLE: always moves to FETCH on the next cycle.
- FETCH: idu_ready=1.
  - ifu_valid&ifu_err: go to HALT, code 2.
  - ifu_valid alone: go to EXEC.
  - ifu_valid with no error takes priority over a watchdog expiry in the same cycle.
- EXEC: lasts exactly 1 cycle. Latches is_mem into mem_q and is_ebreak into ebreak_q.
  - is_mem=1: go to MEM.
  - otherwise: go to COMMIT.
- MEM, request phase: exu_valid=1 until the cycle lsu_ready=1, then 0 for the rest of MEM.
- MEM, completion:
  - lsu_valid&lsu_err: go to HALT, code 2.
  - lsu_valid alone: go to COMMIT.
  - lsu_valid may arrive in the same cycle as lsu_ready.
  - an error takes priority over a clean completion.
- COMMIT: commit=1 for exactly 1 cycle; minstret increments.
  - ebreak_q=1: go to HALT, code 1. The ebreak itself retires.
  - otherwise: go to FETCH.
- HALT: halt=1; all other strobes are 0. The state holds until rst; the first halt_code is kept.
- Watchdog:
  - The counter clears on every state change.
  - It increments each cycle spent in FETCH or MEM.
  - When it reaches WDT_LIMIT-1 with no exit condition that cycle, the next state is HALT, code 3.
- mcycle: increments every cycle the state is not HALT, IDLE included.
- Counter overflow: mcycle and minstret wrap silently from all-ones to 0.
- Latency:
  - non-memory instruction with a 1-cycle fetch: 3 cycles (FETCH, EXEC, COMMIT).
  - memory instruction with a 1-cycle LSU: 4 cycles.
- Spurious inputs are ignored:
  - ifu_valid outside FETCH.
  - lsu_ready or lsu_valid outside MEM.
- Commit and halt are mutually exclusive in any single cycle.

Test Plan:
- Reset release, then ifu_valid held 1, is_mem=0, is_ebreak=0 → states IDLE,FETCH,EXEC,COMMIT repeat. commit pulses every 3rd cycle; after 10 instructions minstret=10 and mcycle=31.
- Load with lsu_ready at MEM cycle 2 and lsu_valid at MEM cycle 5 → exu_valid high for exactly 2 cycles. commit occurs 1 cycle after lsu_valid; minstret increments by 1.
- ebreak (is_ebreak=1 in EXEC) → commit pulses once, then halt=1 and halt_code=1. Further ifu_valid pulses leave minstret and mcycle frozen.
- ifu_valid=1 with ifu_err=1 in FETCH → no commit; HALT next cycle, halt_code=2. Same check in MEM with lsu_valid=lsu_err=1.
- WDT_LIMIT=8, ifu_valid held 0 → HALT entered after exactly 8 FETCH cycles, halt_code=3. Repeat with ifu_valid=1 on the 8th cycle → EXEC, no halt.
- Assert rst while in MEM with a pending LSU request → next cycle state_dbg=0, exu_valid=0, counters=0. Normal fetch resumes after deassertion.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// ============================================================================
// Module      : exec_sequencer_if
// Description : Handshake, status and counter bundle of the execution sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface exec_sequencer_if #(
  parameter int CNT_W = 64
);
  logic             ifu_valid;
  logic             ifu_err;
  logic             idu_ready;
  logic             is_mem;
  logic             is_ebreak;
  logic             exu_valid;
  logic             lsu_ready;
  logic             lsu_valid;
  logic             lsu_err;
  logic             commit;
  logic             halt;
  logic [1:0]       halt_code;
  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;
  logic [2:0]       state_dbg;

  // Sequencer side
  modport master (
    input  ifu_valid, ifu_err, is_mem, is_ebreak, lsu_ready, lsu_valid, lsu_err,
    output idu_ready, exu_valid, commit, halt, halt_code, mcycle, minstret, state_dbg
  );

  // Core pipeline / environment side
  modport slave (
    output ifu_valid, ifu_err, is_mem, is_ebreak, lsu_ready, lsu_valid, lsu_err,
    input  idu_ready, exu_valid, commit, halt, halt_code, mcycle, minstret, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/exec_sequencer.sv
// ============================================================================
// Module      : exec_sequencer
// Description : Multi-cycle fetch/exec/mem/commit controller with halt causes,
//               watchdog and mcycle/minstret counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module exec_sequencer #(
  parameter int WDT_LIMIT = 1024,
  parameter int CNT_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  exec_sequencer_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [15:0]      c_WDT_MAX     = 16'(WDT_LIMIT - 1);
  localparam logic [1:0]       c_CODE_NONE   = 2'd0;
  localparam logic [1:0]       c_CODE_EBREAK = 2'd1;
  localparam logic [1:0]       c_CODE_BUS    = 2'd2;
  localparam logic [1:0]       c_CODE_WDT    = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [15:0]      r_wdt;
  logic             r_ebreak_q;
  logic             r_idu_ready;
  logic             r_exu_valid;
  logic             r_commit;
  logic             r_halt;
  logic [1:0]       r_halt_code;
  logic [CNT_W-1:0] r_mcycle;
  logic [CNT_W-1:0] r_minstret;

  state_t           w_nxt;
  logic [1:0]       w_code;
  logic             w_wdt_exp;

  assign w_wdt_exp = (r_wdt == c_WDT_MAX);

  // Exit conditions are tested before the watchdog so a same-cycle handshake wins.
  always_comb begin
    w_nxt  = r_state;
    w_code = c_CODE_NONE;
    case (r_state)
      S_IDLE:   w_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.ifu_valid && bus.ifu_err) begin
          w_nxt  = S_HALT;
          w_code = c_CODE_BUS;
        end else if (bus.ifu_valid) begin
          w_nxt = S_EXEC;
        end else if (w_wdt_exp) begin
          w_nxt  = S_HALT;
          w_code = c_CODE_WDT;
        end
      end
      S_EXEC:   w_nxt = bus.is_mem ? S_MEM : S_COMMIT;
      S_MEM: begin
        if (bus.lsu_valid && bus.lsu_err) begin
          w_nxt  = S_HALT;
          w_code = c_CODE_BUS;
        end else if (bus.lsu_valid) begin
          w_nxt = S_COMMIT;
        end else if (w_wdt_exp) begin
          w_nxt  = S_HALT;
          w_code = c_CODE_WDT;
        end
      end
      S_COMMIT: begin
        if (r_ebreak_q) begin
          w_nxt  = S_HALT;
          w_code = c_CODE_EBREAK;
        end else begin
          w_nxt = S_FETCH;
        end
      end
      S_HALT:   w_nxt = S_HALT;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wdt       <= 16'd0;
      r_ebreak_q  <= 1'b0;
      r_idu_ready <= 1'b0;
      r_exu_valid <= 1'b0;
      r_commit    <= 1'b0;
      r_halt      <= 1'b0;
      r_halt_code <= c_CODE_NONE;
      r_mcycle    <= '0;
      r_minstret  <= '0;
    end else begin
      r_state <= w_nxt;

      if (w_nxt != r_state) begin
        r_wdt <= 16'd0;
      end else if (r_state == S_FETCH || r_state == S_MEM) begin
        r_wdt <= r_wdt + 16'd1;
      end

      if (r_state == S_EXEC) begin
        r_ebreak_q <= bus.is_ebreak;
      end

      // Outputs are registered from the next state so they line up with it.
      r_idu_ready <= (w_nxt == S_FETCH);
      r_commit    <= (w_nxt == S_COMMIT);
      r_halt      <= (w_nxt == S_HALT);
      r_exu_valid <= (w_nxt == S_MEM) &&
                     ((r_state == S_EXEC) || (r_exu_valid && !bus.lsu_ready));

      if (r_state != S_HALT && w_nxt == S_HALT) begin
        r_halt_code <= w_code;
      end

      if (r_state != S_HALT) begin
        r_mcycle <= r_mcycle + c_CNT_ONE;
      end
      if (r_state == S_COMMIT) begin
        r_minstret <= r_minstret + c_CNT_ONE;
      end
    end
  end

  assign bus.idu_ready = r_idu_ready;
  assign bus.exu_valid = r_exu_valid;
  assign bus.commit    = r_commit;
  assign bus.halt      = r_halt;
  assign bus.halt_code = r_halt_code;
  assign bus.mcycle    = r_mcycle;
  assign bus.minstret  = r_minstret;
  assign bus.state_dbg = r_state;

endmodule

`default_nettype wire
